logic_unit_pipe: RTL
====================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width in bits (legal range 1..64).
REQ-002 Parameter CNT_W, default 16, width of the delivered-result counter.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present on op/a/b/acc_sel.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 op  input  3  operation select; encoding given in REQ-013.
REQ-008 acc_sel  input  1  1 = operand B is replaced by the accumulator.
REQ-009 acc_clr  input  1  synchronous clear of the accumulator.
REQ-010 a, b  input  WIDTH each  operands.
REQ-011 out_valid  output  1; out_ready  input  1; out  output  WIDTH  result; zero  output  1  result is all-zero.
REQ-012 count  output  CNT_W  number of results delivered since reset, saturating.

Function
REQ-013 op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A (b ignored), 111 LOR = zero-extended (|a || |b_eff).
REQ-014 b_eff = acc when acc_sel=1, else b.
REQ-015 Accept = in_valid && in_ready; on accept, result and zero flag are computed from the current inputs and pushed into a 2-entry output FIFO.
REQ-016 in_ready = FIFO not full; it does not depend combinationally on out_ready.
REQ-017 Deliver = out_valid && out_ready; out_valid = FIFO not empty; out/zero show the head entry.
REQ-018 Latency: a request accepted at edge N is presented on out no earlier than the cycle after edge N; results leave in acceptance order.
REQ-019 Push and pop at the same edge with 1 entry stored: occupancy stays 1 and the new result becomes head.
REQ-020 out/zero hold stable while out_valid=1 and out_ready=0.
REQ-021 On every accept the accumulator loads that accept's result, regardless of acc_sel.
REQ-022 acc_clr=1 loads accumulator 0 at the edge; it takes priority over REQ-021, but an op accepted in the same cycle still uses the pre-clear accumulator as b_eff.
REQ-023 count increments by 1 per deliver and stops at 2^CNT_W-1.
REQ-024 out and zero are 0 whenever out_valid=0.

Reset
REQ-025 While rst=1: FIFO empty, out_valid=0, in_ready=0, out=0, zero=0, accumulator=0, count=0.
REQ-026 in_ready rises in the first cycle after rst deasserts.
REQ-027 Reset mid-operation discards all buffered results without delivering them.

Structure
REQ-028 Package logic_unit_pkg holds the op encoding constants/enum, the default WIDTH, and the default CNT_W.
REQ-029 The 2-entry buffer is sub-module lu_fifo2, parametrised by data width, with push/pop/full/empty ports.
REQ-030 The operation decode is combinational and lies between the input port and the lu_fifo2 write port; no other pipeline register exists.

Verification (WIDTH=4)
REQ-031 Case OR: a=0101, b=1010, op=001, out_ready=1 -> out=1111, zero=0, count=1.
REQ-032 Case LOR: a=0101, b=0000, op=111 -> out=0001; then a=0000, b=0000 -> out=0000, zero=1.
REQ-033 Case backpressure: out_ready=0 while issuing AND requests 1111&0011, 1111&0101, then 1111&1001 -> in_ready=0 after two accepts; raise out_ready -> outputs 0011, 0101, 1001 in that order.
REQ-034 Case accumulate: pulse acc_clr; XOR a=0011 with acc_sel=1 -> out=0011; XOR a=0101 with acc_sel=1 -> out=0110.
REQ-035 Case reset mid-operation: two results buffered, out_ready=0, pulse rst asynchronously -> out_valid=0, count=0, accumulator=0 immediately; nothing is delivered afterwards.
REQ-036 Case saturation: with CNT_W=2, deliver 5 results -> count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit.
// Op encoding and default widths.
package logic_unit_pkg;

    localparam int LU_WIDTH = 4;
    localparam int LU_CNT_W = 16;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_LOR  = 3'b111
    } lu_op_e;

endpackage

// File: rtl/lu_fifo2.sv
// Two-entry result buffer; head entry is shown on dout.
// dout reads as zero when the buffer is empty.
module lu_fifo2 #(
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [1:0]    cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : e0;

    // Storage and occupancy update; a push+pop with one entry replaces the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= din;
                    else             e1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Logic unit with accumulator operand, 2-deep result buffer
// and a saturating delivered-result counter.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = LU_WIDTH,
    parameter int CNT_W = LU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] res;
    logic             res_zero;
    logic [WIDTH:0]   head;
    logic             full;
    logic             empty;
    logic             accept;
    logic             deliver;

    assign b_eff     = acc_sel ? acc : b;
    assign in_ready  = !full && !rst;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign res_zero  = (res == '0);
    assign out       = head[WIDTH-1:0];
    assign zero      = head[WIDTH];

    // Operation decode from the current inputs.
    always_comb begin
        res = '0;
        unique case (lu_op_e'(op))
            OP_AND:  res = a & b_eff;
            OP_OR:   res = a | b_eff;
            OP_XOR:  res = a ^ b_eff;
            OP_NAND: res = ~(a & b_eff);
            OP_NOR:  res = ~(a | b_eff);
            OP_XNOR: res = ~(a ^ b_eff);
            OP_NOTA: res = ~a;
            OP_LOR:  res[0] = (|a) || (|b_eff);
        endcase
    end

    lu_fifo2 #(
        .DW(WIDTH + 1)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (accept),
        .pop  (deliver),
        .din  ({res_zero, res}),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    // Accumulator: clear wins, otherwise it tracks each accepted result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          acc <= '0;
        else if (acc_clr) acc <= '0;
        else if (accept)  acc <= res;
    end

    // Delivered-result counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (deliver && (count != {CNT_W{1'b1}}))
            count <= count + CNT_W'(1);
    end

endmodule
